// File: rtl/multicycle_ctrl_unit.sv
// Multicycle control unit: FETCH-DECODE-EXEC-WB sequencer with
// maskable interrupt entry (EPC save), RETI and HALT.
module multicycle_ctrl_unit #(
    parameter int           DW       = 8,
    parameter int           AW       = 8,
    parameter int           RSEL     = 2,
    parameter logic [AW-1:0] IRQ_VEC = 8'hFD,
    parameter bit           IE_RESET = 1'b1,
    localparam int          IW       = 4 + 2 * RSEL
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            irq_req,
    output logic            irq_ack,
    input  logic [IW-1:0]   instr_data,
    input  logic [AW-1:0]   pc_addr,
    output logic            pc_inc,
    output logic            pc_jump,
    output logic [AW-1:0]   pc_jmpaddr,
    output logic [RSEL-1:0] regfile_read1,
    output logic [RSEL-1:0] regfile_read2,
    input  logic [DW-1:0]   regfile_out1,
    input  logic [DW-1:0]   regfile_out2,
    output logic [RSEL-1:0] regfile_writereg,
    output logic [DW-1:0]   regfile_data,
    output logic            regfile_op,
    output logic [3:0]      alu_opcode,
    input  logic [DW-1:0]   alu_out,
    output logic [AW-1:0]   usermem_address,
    output logic [DW-1:0]   usermem_data,
    input  logic [DW-1:0]   usermem_rdata,
    output logic            rw,
    output logic            halted,
    output logic            in_isr
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_WB, S_INT, S_HALT
    } state_t;

    state_t          r_state, w_state_n;
    logic [IW-1:0]   r_instr, w_instr_n;
    logic [AW-1:0]   r_epc, w_epc_n;
    logic            r_ie, w_ie_n;
    logic            r_in_isr, w_in_isr_n;

    logic [3:0]      w_op;
    logic [RSEL-1:0] w_rd;
    logic [RSEL-1:0] w_rs;
    logic            w_is_alu;
    logic            w_irq;

    // Data words become addresses by truncation or zero-extension.
    function automatic logic [AW-1:0] to_addr(input logic [DW-1:0] d);
        return AW'(d);
    endfunction

    assign w_op     = r_instr[IW-1:IW-4];
    assign w_rd     = r_instr[2*RSEL-1:RSEL];
    assign w_rs     = r_instr[RSEL-1:0];
    assign w_is_alu = (w_op != 4'h0) && !w_op[3];
    assign w_irq    = irq_req && r_ie && !r_in_isr;
    assign in_isr   = r_in_isr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_instr  <= '0;
            r_epc    <= '0;
            r_ie     <= IE_RESET;
            r_in_isr <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_instr  <= w_instr_n;
            r_epc    <= w_epc_n;
            r_ie     <= w_ie_n;
            r_in_isr <= w_in_isr_n;
        end
    end

    always_comb begin
        w_state_n        = r_state;
        w_instr_n        = r_instr;
        w_epc_n          = r_epc;
        w_ie_n           = r_ie;
        w_in_isr_n       = r_in_isr;
        irq_ack          = 1'b0;
        pc_inc           = 1'b0;
        pc_jump          = 1'b0;
        pc_jmpaddr       = '0;
        regfile_read1    = '0;
        regfile_read2    = '0;
        regfile_writereg = '0;
        regfile_data     = '0;
        regfile_op       = 1'b0;
        alu_opcode       = 4'h0;
        usermem_address  = '0;
        usermem_data     = '0;
        rw               = 1'b0;
        halted           = 1'b0;
        // Read selects and ALU op stay stable from DECODE through WB.
        if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_WB) begin
            regfile_read1 = w_rd;
            regfile_read2 = w_rs;
            if (w_is_alu) alu_opcode = w_op;
        end
        case (r_state)
            S_FETCH: begin
                if (w_irq) begin
                    w_state_n = S_INT;
                end else begin
                    w_instr_n = instr_data;
                    w_state_n = S_DECODE;
                end
            end
            S_DECODE: w_state_n = S_EXEC;
            S_EXEC: begin
                w_state_n = S_WB;
                if (w_op == 4'h8) begin
                    usermem_address = to_addr(regfile_out2);
                end else if (w_op == 4'h9) begin
                    usermem_address = to_addr(regfile_out1);
                    usermem_data    = regfile_out2;
                    rw              = 1'b1;
                end
            end
            S_WB: begin
                w_state_n = S_FETCH;
                if (w_is_alu) begin
                    regfile_op       = 1'b1;
                    regfile_writereg = w_rd;
                    regfile_data     = alu_out;
                    pc_inc           = 1'b1;
                end else begin
                    case (w_op)
                        4'h8: begin
                            usermem_address  = to_addr(regfile_out2);
                            regfile_op       = 1'b1;
                            regfile_writereg = w_rd;
                            regfile_data     = usermem_rdata;
                            pc_inc           = 1'b1;
                        end
                        4'hA: begin
                            pc_jump    = 1'b1;
                            pc_jmpaddr = to_addr(regfile_out2);
                        end
                        4'hB: begin
                            if (regfile_out1 == '0) begin
                                pc_jump    = 1'b1;
                                pc_jmpaddr = to_addr(regfile_out2);
                            end else begin
                                pc_inc = 1'b1;
                            end
                        end
                        4'hC: begin
                            w_ie_n = 1'b1;
                            pc_inc = 1'b1;
                        end
                        4'hD: begin
                            w_ie_n = 1'b0;
                            pc_inc = 1'b1;
                        end
                        4'hE: begin
                            pc_jump    = 1'b1;
                            pc_jmpaddr = r_epc;
                            w_in_isr_n = 1'b0;
                        end
                        4'hF: begin
                            pc_inc    = 1'b1;
                            w_state_n = S_HALT;
                        end
                        default: pc_inc = 1'b1;
                    endcase
                end
            end
            S_INT: begin
                // pc_addr already points past the interrupted instruction.
                w_epc_n    = pc_addr;
                pc_jump    = 1'b1;
                pc_jmpaddr = IRQ_VEC;
                irq_ack    = 1'b1;
                w_in_isr_n = 1'b1;
                w_state_n  = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
                if (irq_req && r_ie) w_state_n = S_INT;
            end
            default: w_state_n = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit with a small PC,
// instruction memory, register file and adder environment.
module tb_multicycle_ctrl_unit;

    logic       clk;
    logic       reset;
    logic       irq_req;
    logic       irq_ack;
    logic [7:0] instr_data;
    logic [7:0] pc_addr;
    logic       pc_inc;
    logic       pc_jump;
    logic [7:0] pc_jmpaddr;
    logic [1:0] regfile_read1;
    logic [1:0] regfile_read2;
    logic [7:0] regfile_out1;
    logic [7:0] regfile_out2;
    logic [1:0] regfile_writereg;
    logic [7:0] regfile_data;
    logic       regfile_op;
    logic [3:0] alu_opcode;
    logic [7:0] alu_out;
    logic [7:0] usermem_address;
    logic [7:0] usermem_data;
    logic [7:0] usermem_rdata;
    logic       rw;
    logic       halted;
    logic       in_isr;

    logic [7:0] imem [256];
    logic [7:0] rf [4];
    logic [7:0] pc;
    logic [7:0] pc_start;

    int n_chk;
    int n_fail;
    int ack_cnt;
    int pulse_cnt;
    int a0;
    int p0;

    multicycle_ctrl_unit dut (
        .clk              (clk),
        .reset            (reset),
        .irq_req          (irq_req),
        .irq_ack          (irq_ack),
        .instr_data       (instr_data),
        .pc_addr          (pc_addr),
        .pc_inc           (pc_inc),
        .pc_jump          (pc_jump),
        .pc_jmpaddr       (pc_jmpaddr),
        .regfile_read1    (regfile_read1),
        .regfile_read2    (regfile_read2),
        .regfile_out1     (regfile_out1),
        .regfile_out2     (regfile_out2),
        .regfile_writereg (regfile_writereg),
        .regfile_data     (regfile_data),
        .regfile_op       (regfile_op),
        .alu_opcode       (alu_opcode),
        .alu_out          (alu_out),
        .usermem_address  (usermem_address),
        .usermem_data     (usermem_data),
        .usermem_rdata    (usermem_rdata),
        .rw               (rw),
        .halted           (halted),
        .in_isr           (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset)        pc <= pc_start;
        else if (pc_jump) pc <= pc_jmpaddr;
        else if (pc_inc)  pc <= pc + 8'd1;
    end

    assign pc_addr       = pc;
    assign instr_data    = imem[pc];
    assign regfile_out1  = rf[regfile_read1];
    assign regfile_out2  = rf[regfile_read2];
    assign alu_out       = regfile_out1 + regfile_out2;
    assign usermem_rdata = 8'h5A;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (irq_ack) ack_cnt++;
        if (irq_ack | pc_inc | pc_jump | regfile_op | rw) pulse_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        ack_cnt   = 0;
        pulse_cnt = 0;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        rf[0] = 8'h20;
        rf[1] = 8'h03;
        rf[2] = 8'h04;
        rf[3] = 8'hAA;
        imem[8'h10] = 8'h16;
        imem[8'h11] = 8'hD0;
        imem[8'h12] = 8'h00;
        imem[8'h13] = 8'hC0;
        imem[8'h14] = 8'h00;
        imem[8'hFD] = 8'h00;
        imem[8'hFE] = 8'hE0;
        imem[8'h20] = 8'h93;
        imem[8'h21] = 8'h88;
        imem[8'h22] = 8'hBC;
        imem[8'h23] = 8'hA0;
        imem[8'h30] = 8'hF0;
        imem[8'h40] = 8'hD0;
        imem[8'h41] = 8'hF0;
        irq_req  = 1'b0;
        pc_start = 8'h10;
        reset    = 1'b1;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_pulses", {30'd0, pc_inc | pc_jump | irq_ack,
                           regfile_op | rw}, 32'd0);
        chk("rst_status", {30'd0, halted, in_isr}, 32'd0);
        chk("rst_addr", usermem_address, 32'h0);
        reset = 1'b0;

        // ADD r1,r2 with interrupt request raised mid-instruction
        tick();
        chk("dec_read1", regfile_read1, 32'd1);
        chk("dec_read2", regfile_read2, 32'd2);
        chk("dec_aluop", alu_opcode, 32'd1);
        irq_req = 1'b1;
        ticks(2);
        chk("add_wb_op", regfile_op, 32'd1);
        chk("add_wb_reg", regfile_writereg, 32'd1);
        chk("add_wb_data", regfile_data, 32'h07);
        chk("add_wb_inc", pc_inc, 32'd1);
        chk("add_wb_jump", pc_jump, 32'd0);
        tick();
        chk("fetch_noack", irq_ack, 32'd0);
        tick();
        chk("int_ack", irq_ack, 32'd1);
        chk("int_jump", pc_jump, 32'd1);
        chk("int_vec", pc_jmpaddr, 32'hFD);
        irq_req = 1'b0;
        tick();
        chk("isr_flag", in_isr, 32'd1);
        chk("isr_pc", pc, 32'hFD);

        // Second request inside the ISR is ignored; RETI returns to 11
        irq_req = 1'b1;
        a0 = ack_cnt;
        ticks(4);
        irq_req = 1'b0;
        ticks(3);
        chk("reti_jump", pc_jump, 32'd1);
        chk("reti_epc", pc_jmpaddr, 32'h11);
        chk("isr_nonest", ack_cnt - a0, 32'd0);
        tick();
        chk("reti_isr", in_isr, 32'd0);
        chk("reti_pc", pc, 32'h11);

        // DI masks a held request; EI lets it in at the next fetch
        ticks(4);
        irq_req = 1'b1;
        a0 = ack_cnt;
        ticks(8);
        chk("di_noack", ack_cnt - a0, 32'd0);
        chk("ei_pc", pc, 32'h14);
        tick();
        chk("ei_ack", irq_ack, 32'd1);
        chk("ei_vec", pc_jmpaddr, 32'hFD);
        irq_req = 1'b0;

        // ST, LD, JZ not taken, JMP
        reset    = 1'b1;
        pc_start = 8'h20;
        tick();
        reset = 1'b0;
        ticks(2);
        chk("st_rw", rw, 32'd1);
        chk("st_addr", usermem_address, 32'h20);
        chk("st_data", usermem_data, 32'hAA);
        tick();
        chk("st_wb_rw", rw, 32'd0);
        chk("st_wb_inc", pc_inc, 32'd1);
        ticks(3);
        chk("ld_addr", usermem_address, 32'h20);
        chk("ld_rw", rw, 32'd0);
        tick();
        chk("ld_wb_op", regfile_op, 32'd1);
        chk("ld_wb_reg", regfile_writereg, 32'd2);
        chk("ld_wb_data", regfile_data, 32'h5A);
        ticks(4);
        chk("jz_nt_inc", pc_inc, 32'd1);
        chk("jz_nt_jump", pc_jump, 32'd0);
        ticks(4);
        chk("jmp_jump", pc_jump, 32'd1);
        chk("jmp_addr", pc_jmpaddr, 32'h20);
        chk("jmp_inc", pc_inc, 32'd0);

        // Reset in the EXEC cycle of ST
        ticks(3);
        chk("st2_rw", rw, 32'd1);
        reset = 1'b1;
        #1;
        chk("rstx_rw", rw, 32'd0);
        chk("rstx_addr", usermem_address, 32'h0);
        chk("rstx_data", usermem_data, 32'h0);
        tick();
        reset = 1'b0;
        chk("rstx_pc", pc, 32'h20);
        tick();
        chk("rstx_dec", regfile_read2, 32'd3);

        // HALT at 30 then interrupt; RETI returns to 31
        reset    = 1'b1;
        pc_start = 8'h30;
        tick();
        reset = 1'b0;
        ticks(3);
        chk("hlt_wb_inc", pc_inc, 32'd1);
        tick();
        chk("hlt_flag", halted, 32'd1);
        chk("hlt_pc", pc, 32'h31);
        ticks(3);
        chk("hlt_stay", halted, 32'd1);
        irq_req = 1'b1;
        tick();
        chk("hlt_ack", irq_ack, 32'd1);
        chk("hlt_int_halted", halted, 32'd0);
        irq_req = 1'b0;
        ticks(8);
        chk("hlt_reti", pc_jump, 32'd1);
        chk("hlt_epc", pc_jmpaddr, 32'h31);

        // DI then HALT: request stays pending, no pulses
        reset    = 1'b1;
        pc_start = 8'h40;
        tick();
        reset = 1'b0;
        ticks(8);
        chk("dhlt_flag", halted, 32'd1);
        irq_req = 1'b1;
        p0 = pulse_cnt;
        ticks(20);
        chk("dhlt_pulses", pulse_cnt - p0, 32'd0);
        chk("dhlt_stay", halted, 32'd1);
        irq_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
